// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: base opcodes, immediate formats and
// default datapath widths used by the decode stage and its immediate generator.
package rv32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  function automatic logic is_base_opcode(input logic [6:0] opc);
    logic legal;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: classifies the instruction's immediate
// format from its opcode and produces the sign-extended 32-bit immediate.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] i_instr,
  output imm_fmt_t    o_fmt,
  output logic [31:0] o_imm
);

  logic [6:0] w_opcode;
  logic       w_sign;

  assign w_opcode = i_instr[6:0];
  assign w_sign   = i_instr[31];

  // Format selection by opcode
  always_comb begin
    o_fmt = IMM_NONE;
    case (w_opcode)
      OPC_JALR, OPC_LOAD, OPC_OPIMM: o_fmt = IMM_I;
      OPC_STORE:                     o_fmt = IMM_S;
      OPC_BRANCH:                    o_fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:            o_fmt = IMM_U;
      OPC_JAL:                       o_fmt = IMM_J;
      default:                       o_fmt = IMM_NONE;
    endcase
  end

  // Immediate assembly; B and J carry an implicit zero LSB
  always_comb begin
    o_imm = 32'd0;
    case (o_fmt)
      IMM_I: o_imm = {{20{w_sign}}, i_instr[31:20]};
      IMM_S: o_imm = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{19{w_sign}}, i_instr[31], i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
      IMM_U: o_imm = {i_instr[31:12], 12'd0};
      IMM_J: o_imm = {{11{w_sign}}, i_instr[31], i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};
      default: o_imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: register-file addressing, WB-to-ID bypass,
// load-use stall detection and the ID/EX pipeline register with its handshake.
module decode_stage
  import rv32_pkg::*;
#(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int REG_AW = rv32_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  input  logic              flush,
  output logic [REG_AW-1:0] rf_read_reg1,
  output logic [REG_AW-1:0] rf_read_reg2,
  input  logic [XLEN-1:0]   rf_read_data1,
  input  logic [XLEN-1:0]   rf_read_data2,
  input  logic              wb_write_enable,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [XLEN-1:0]   wb_write_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [6:0]        ex_opcode,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_is_load,
  output logic              ex_illegal
);

  logic [6:0]        w_opcode;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [REG_AW-1:0] w_rd;
  logic              w_uses_rs1;
  logic              w_uses_rs2;
  logic              w_legal;
  logic              w_has_rd;
  logic              w_hazard;
  logic              w_accept;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  imm_fmt_t          w_fmt;
  logic [31:0]       w_imm;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rd;
  logic [6:0]        r_opcode;
  logic [2:0]        r_funct3;
  logic              r_funct7b5;
  logic              r_is_load;
  logic              r_illegal;

  assign w_opcode     = if_instr[6:0];
  assign w_rs1        = if_instr[19:15];
  assign w_rs2        = if_instr[24:20];
  assign w_rd         = if_instr[11:7];
  assign rf_read_reg1 = w_rs1;
  assign rf_read_reg2 = w_rs2;

  imm_gen u_imm_gen (
    .i_instr (if_instr),
    .o_fmt   (w_fmt),
    .o_imm   (w_imm)
  );

  // Source-register usage and legality per opcode
  always_comb begin
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_legal    = 1'b1;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b0;
      end
      OPC_BRANCH, OPC_STORE, OPC_OP: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      default: begin
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        w_legal    = 1'b0;
      end
    endcase
  end

  // Stores and branches are the only legal formats without a destination
  assign w_has_rd = w_legal && (w_fmt != IMM_S) && (w_fmt != IMM_B);

  assign w_hazard = r_valid && r_is_load && (r_rd != {REG_AW{1'b0}}) &&
                    ((w_uses_rs1 && (w_rs1 == r_rd)) ||
                     (w_uses_rs2 && (w_rs2 == r_rd)));

  assign if_ready = !flush && !w_hazard && (!r_valid || ex_ready);
  assign w_accept = if_valid && if_ready;

  // The register file writes on the same edge, so its read is still stale
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [REG_AW-1:0] idx,
    input logic [XLEN-1:0]   rf_data
  );
    logic [XLEN-1:0] val;
    if (idx == {REG_AW{1'b0}}) begin
      val = {XLEN{1'b0}};
    end else if (wb_write_enable && (wb_write_reg == idx)) begin
      val = wb_write_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  // Operand selection for both sources
  always_comb begin
    w_op1 = sel_operand(w_rs1, rf_read_data1);
    w_op2 = sel_operand(w_rs2, rf_read_data2);
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= {XLEN{1'b0}};
      r_rs1_data <= {XLEN{1'b0}};
      r_rs2_data <= {XLEN{1'b0}};
      r_imm      <= {XLEN{1'b0}};
      r_rd       <= {REG_AW{1'b0}};
      r_opcode   <= 7'd0;
      r_funct3   <= 3'd0;
      r_funct7b5 <= 1'b0;
      r_is_load  <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= if_pc;
      r_rs1_data <= w_op1;
      r_rs2_data <= w_op2;
      r_imm      <= XLEN'(w_imm);
      r_rd       <= w_has_rd ? w_rd : {REG_AW{1'b0}};
      r_opcode   <= w_opcode;
      r_funct3   <= if_instr[14:12];
      r_funct7b5 <= if_instr[30];
      r_is_load  <= (w_opcode == OPC_LOAD);
      r_illegal  <= !w_legal;
    end else if (ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_pc       = r_pc;
  assign ex_rs1_data = r_rs1_data;
  assign ex_rs2_data = r_rs2_data;
  assign ex_imm      = r_imm;
  assign ex_rd       = r_rd;
  assign ex_opcode   = r_opcode;
  assign ex_funct3   = r_funct3;
  assign ex_funct7b5 = r_funct7b5;
  assign ex_is_load  = r_is_load;
  assign ex_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic compared against an instruction-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b1;
  logic        wb_we = 1'b0;
  logic [31:0] if_instr = 32'd0;
  logic [31:0] if_pc = 32'd0;
  logic [31:0] rd1 = 32'd0;
  logic [31:0] rd2 = 32'd0;
  logic [31:0] wb_data = 32'd0;
  logic [4:0]  wb_reg = 5'd0;

  logic        if_ready, ex_valid, ex_funct7b5, ex_is_load, ex_illegal;
  logic [4:0]  rf_read_reg1, rf_read_reg2, ex_rd;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rd1), .rf_read_data2(rd2),
    .wb_write_enable(wb_we), .wb_write_reg(wb_reg), .wb_write_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_is_load(ex_is_load), .ex_illegal(ex_illegal)
  );

  int checks = 0;
  int failures = 0;

  // Reference model of the ID/EX contents
  logic        m_valid = 1'b0, m_f7 = 1'b0, m_load = 1'b0, m_ill = 1'b0;
  logic [31:0] m_pc = 32'd0, m_rs1 = 32'd0, m_rs2 = 32'd0, m_imm = 32'd0;
  logic [4:0]  m_rd = 5'd0;
  logic [6:0]  m_opc = 7'd0;
  logic [2:0]  m_f3 = 3'd0;
  logic        m_ready = 1'b0;
  logic        obs_ready;
  logic [9:0]  obs_rr;

  logic [146:0] dut_vec, m_vec;
  assign dut_vec = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
                    ex_opcode, ex_funct3, ex_funct7b5, ex_is_load, ex_illegal};
  assign m_vec   = {m_valid, m_pc, m_rs1, m_rs2, m_imm, m_rd,
                    m_opc, m_f3, m_f7, m_load, m_ill};

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic signed [31:0] t;
    t = v << (32 - bits);
    return t >>> (32 - bits);
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: return sext(ins >> 20, 12);
      7'h23: return sext(((ins >> 25) << 5) | ((ins >> 7) & 32'd31), 12);
      7'h63: return sext(((ins >> 31) << 12) | (((ins >> 7) & 32'd1) << 11) |
                         (((ins >> 25) & 32'd63) << 5) | (((ins >> 8) & 32'd15) << 1), 13);
      7'h37, 7'h17: return ins & 32'hFFFFF000;
      7'h6F: return sext(((ins >> 31) << 20) | (((ins >> 12) & 32'd255) << 12) |
                         (((ins >> 20) & 32'd1) << 11) | (((ins >> 21) & 32'd1023) << 1), 21);
      default: return 32'd0;
    endcase
  endfunction

  // 0: no sources, 1: rs1 only, 2: rs1 and rs2
  function automatic int src_kind(input logic [6:0] opc);
    case (opc)
      7'h67, 7'h03, 7'h13: return 1;
      7'h63, 7'h23, 7'h33: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic legal(input logic [6:0] opc);
    case (opc)
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_op(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && wb_reg == idx) return wb_data;
    return rf;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic exr);
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_ready = exr;
  endtask

  // Advance one clock: sample handshake, step the model, wait past the edge
  task automatic tick();
    logic hz, acc;
    int   k;
    #2;
    obs_ready = if_ready;
    obs_rr    = {rf_read_reg1, rf_read_reg2};
    k  = src_kind(if_instr[6:0]);
    hz = m_valid && m_load && (m_rd != 5'd0) &&
         ((k >= 1 && if_instr[19:15] == m_rd) || (k == 2 && if_instr[24:20] == m_rd));
    m_ready = !flush && !hz && (!m_valid || ex_ready);
    acc = if_valid && m_ready;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_pc = 32'd0; m_rs1 = 32'd0; m_rs2 = 32'd0; m_imm = 32'd0;
      m_rd = 5'd0; m_opc = 7'd0; m_f3 = 3'd0; m_f7 = 1'b0; m_load = 1'b0; m_ill = 1'b0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1;
      m_pc    = if_pc;
      m_rs1   = ref_op(if_instr[19:15], rd1);
      m_rs2   = ref_op(if_instr[24:20], rd2);
      m_imm   = ref_imm(if_instr);
      m_opc   = if_instr[6:0];
      m_ill   = !legal(m_opc);
      m_rd    = (legal(m_opc) && m_opc != 7'h63 && m_opc != 7'h23) ? if_instr[11:7] : 5'd0;
      m_f3    = if_instr[14:12];
      m_f7    = if_instr[30];
      m_load  = (m_opc == 7'h03);
    end else if (ex_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    tick();
    checks++;
    if (dut_vec !== 147'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", dut_vec);
    end
    checks++;
    if (obs_ready !== 1'b1) begin
      failures++; $display("FAIL reset_if_ready got=%b exp=1", obs_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    drive(1'b1, 32'h00500093, 32'h00000100, 1'b0, 1'b1);
    rd1 = 32'h00000055; rd2 = $urandom;
    tick();
    checks++;
    if (obs_ready !== 1'b1) begin
      failures++; $display("FAIL addi_ready got=%b exp=1", obs_ready);
    end
    checks++;
    if ({ex_valid, ex_rd, ex_imm, ex_rs1_data, ex_opcode} !==
        {1'b1, 5'd1, 32'd5, 32'd0, 7'h13}) begin
      failures++;
      $display("FAIL addi_fields got v=%b rd=%0d imm=%h rs1=%h opc=%h exp v=1 rd=1 imm=5 rs1=0 opc=13",
               ex_valid, ex_rd, ex_imm, ex_rs1_data, ex_opcode);
    end
    checks++;
    if (dut_vec !== m_vec) begin
      failures++; $display("FAIL addi_model got=%h exp=%h", dut_vec, m_vec);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h0000A103, 32'h00000200, 1'b0, 1'b1);
    tick();
    checks++;
    if ({ex_valid, ex_is_load, ex_rd} !== {1'b1, 1'b1, 5'd2}) begin
      failures++; $display("FAIL lw_accept got v=%b ld=%b rd=%0d exp 1 1 2", ex_valid, ex_is_load, ex_rd);
    end
    drive(1'b1, 32'h001101B3, 32'h00000204, 1'b0, 1'b1);
    tick();
    checks++;
    if ({obs_ready, ex_valid} !== 2'b00) begin
      failures++; $display("FAIL load_use_stall got ready=%b v=%b exp 0 0", obs_ready, ex_valid);
    end
    tick();
    checks++;
    if ({obs_ready, ex_valid, ex_rd, ex_pc} !== {1'b1, 1'b1, 5'd3, 32'h00000204}) begin
      failures++;
      $display("FAIL load_use_resume got ready=%b v=%b rd=%0d pc=%h exp 1 1 3 204",
               obs_ready, ex_valid, ex_rd, ex_pc);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, 32'h00028313, 32'h00000300, 1'b0, 1'b1);
    rd1 = 32'd0; wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    checks++;
    if (ex_rs1_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bypass_x5 got=%h exp=deadbeef", ex_rs1_data);
    end
    drive(1'b1, 32'h00000313, 32'h00000304, 1'b0, 1'b1);
    rd1 = 32'h00001234; wb_reg = 5'd0; wb_data = 32'd7;
    tick();
    checks++;
    if (ex_rs1_data !== 32'd0) begin
      failures++; $display("FAIL bypass_x0 got=%h exp=0", ex_rs1_data);
    end
    drive(1'b1, 32'h00028313, 32'h00000308, 1'b0, 1'b1);
    wb_reg = 5'd6; wb_data = 32'h0BADF00D;
    tick();
    checks++;
    if (ex_rs1_data !== 32'h00001234) begin
      failures++; $display("FAIL bypass_other_reg got=%h exp=1234", ex_rs1_data);
    end
    wb_we = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [146:0] snap;
    drive(1'b1, 32'h00100113, 32'h00000400, 1'b0, 1'b1);
    tick();
    snap = dut_vec;
    drive(1'b1, 32'h00200193, 32'h00000404, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_ready !== 1'b0 || dut_vec !== snap || ex_valid !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d ready=%b got=%h exp=%h", i, obs_ready, dut_vec, snap);
      end
    end
    ex_ready = 1'b1;
    tick();
    checks++;
    if ({obs_ready, ex_valid, ex_pc, ex_rd} !== {1'b1, 1'b1, 32'h00000404, 5'd3}) begin
      failures++;
      $display("FAIL backpressure_release got ready=%b v=%b pc=%h rd=%0d exp 1 1 404 3",
               obs_ready, ex_valid, ex_pc, ex_rd);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h00500093, 32'h00000500, 1'b1, 1'b0);
    tick();
    checks++;
    if ({obs_ready, ex_valid} !== 2'b00) begin
      failures++; $display("FAIL flush got ready=%b v=%b exp 0 0", obs_ready, ex_valid);
    end
    drive(1'b1, 32'h00500093, 32'h00000504, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'h00028313, 32'h00000508, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    checks++;
    if (dut_vec !== 147'd0) begin
      failures++; $display("FAIL midstream_reset got=%h exp=0", dut_vec);
    end
  endtask

  task automatic test_imm();
    drive(1'b1, 32'hFE000EE3, 32'h00000600, 1'b0, 1'b1);
    tick();
    checks++;
    if ({ex_imm, ex_rd} !== {32'hFFFFFFFC, 5'd0}) begin
      failures++; $display("FAIL imm_beq got imm=%h rd=%0d exp fffffffc 0", ex_imm, ex_rd);
    end
    drive(1'b1, 32'h123452B7, 32'h00000604, 1'b0, 1'b1);
    tick();
    checks++;
    if ({ex_imm, ex_rd} !== {32'h12345000, 5'd5}) begin
      failures++; $display("FAIL imm_lui got imm=%h rd=%0d exp 12345000 5", ex_imm, ex_rd);
    end
    drive(1'b1, 32'h0000057F, 32'h00000608, 1'b0, 1'b1);
    tick();
    checks++;
    if ({ex_illegal, ex_rd, ex_imm} !== {1'b1, 5'd0, 32'd0}) begin
      failures++; $display("FAIL illegal_opcode got ill=%b rd=%0d imm=%h exp 1 0 0", ex_illegal, ex_rd, ex_imm);
    end
  endtask

  task automatic test_random();
    logic [6:0]  opcs [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B};
    logic [31:0] ins;
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) != 0) begin
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        ins[11:7]  = 5'($urandom_range(0, 3));
      end
      drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0);
      rd1 = $urandom; rd2 = $urandom;
      wb_we = 1'($urandom_range(0, 1)); wb_reg = 5'($urandom_range(0, 3)); wb_data = $urandom;
      tick();
      checks++;
      if (obs_ready !== m_ready || obs_rr !== {ins[19:15], ins[24:20]}) begin
        failures++;
        $display("FAIL rand_handshake n=%0d ready=%b exp=%b rr=%h exp=%h", n, obs_ready, m_ready,
                 obs_rr, {ins[19:15], ins[24:20]});
      end
      checks++;
      if (dut_vec !== m_vec) begin
        failures++; $display("FAIL rand_idex n=%0d instr=%h got=%h exp=%h", n, ins, dut_vec, m_vec);
      end
    end
    wb_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_bypass();
    test_backpressure();
    test_flush();
    test_imm();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
